// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and default sizes for the programmable sequence detector.
package seq_det_pkg;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: shift history, saturating fill count and masked pattern compare with a combinational hit.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               sample_i,
    input  logic               bit_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               overlap_i,
    output logic               hit_o
);
    logic [MAX_LEN-1:0] hist_q, hist_d, mask;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W:0]     fill_inc;
    always_comb begin
        hist_d   = {hist_q[MAX_LEN-2:0], bit_i};
        mask     = ~({MAX_LEN{1'b1}} << len_i);
        fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
        hit_o    = sample_i && (fill_inc >= {1'b0, len_i}) && (((hist_d ^ pattern_i) & mask) == '0);
        // Non-overlapping mode drops the completing bit from the next candidate
        fill_d   = (hit_o && !overlap_i) ? '0 :
                   (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_inc[LEN_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (sample_i) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time programmable serial pattern detector with config/arm/count/done controller.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic               in,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q, cfg_ok_q, cfg_err_q, match_q, match_d;
    logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_d, cnt_inc;
    logic               cfg_hs, cfg_legal, arm, sample, hit;
    assign cfg_ready = state_q != ST_ARMED;
    assign busy      = state_q == ST_ARMED;
    assign done      = state_q == ST_DONE;
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign arm       = start && !abort && cfg_ok_q && (state_q != ST_ARMED);
    assign sample    = (state_q == ST_ARMED) && in_valid && !abort;
    seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (arm),
        .sample_i  (sample),
        .bit_i     (in),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .overlap_i (ovl_q),
        .hit_o     (hit)
    );
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        match_d = hit;
        cnt_d   = (arm || (cfg_hs && cfg_legal)) ? '0 : hit ? cnt_inc : cnt_q;
        state_d = abort ? ST_IDLE :
                  arm ? ST_ARMED :
                  (hit && tgt_q != '0 && cnt_inc == tgt_q) ? ST_DONE :
                  (cfg_hs && state_q == ST_DONE) ? ST_IDLE : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            cfg_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            if (cfg_hs && cfg_legal) begin
                pat_q     <= cfg_pattern;
                len_q     <= cfg_len;
                ovl_q     <= cfg_overlap;
                tgt_q     <= cfg_target;
                cfg_ok_q  <= 1'b1;
                cfg_err_q <= 1'b0;
            end else if (cfg_hs) begin
                cfg_err_q <= 1'b1;
            end
        end
    end
endmodule
